operand_fetch_stage: RTL and testbench

Operand-fetch pipeline stage directly upstream of the ALU in the 8-bit processor. Holds the 8-entry general register file and the carry flag, and reads two operands with same-cycle writeback bypass. Registers InputA/InputB/OP/funct/carry_in into the execute stage, stalling via an interlock on read-after-write hazards. Writeback results and carry updates return through a dedicated write port.

---
 rtl/operand_fetch_stage.sv | 131 +++++++++++++
 tb/tb_operand_fetch_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: register file and carry flag with same-cycle writeback
// bypass, a read-after-write interlock, and a stall-holdable EX payload for the ALU.
module operand_fetch_stage #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] rs_a,
  input  logic [AW-1:0] rs_b,
  input  logic          use_imm,
  input  logic [W-1:0]  imm_in,
  input  logic [3:0]    op_in,
  input  logic [1:0]    funct_in,
  input  logic [AW-1:0] rd_in,
  input  logic          rd_we_in,
  input  logic          carry_we_in,
  input  logic          uses_carry_in,
  input  logic          stall,
  output logic          ex_valid,
  output logic [W-1:0]  InputA,
  output logic [W-1:0]  InputB,
  output logic [3:0]    OP,
  output logic [1:0]    funct,
  output logic          carry_in,
  output logic [AW-1:0] ex_rd,
  output logic          ex_rd_we,
  output logic          ex_carry_we,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_rd,
  input  logic [W-1:0]  wb_data,
  input  logic          wb_carry_en,
  input  logic          wb_carry
);
  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both high; in_valid may stay high while in_ready is low.
  // The EX side has no ready: stall freezes the payload, ex_valid marks it.
  localparam int NREG = 1 << AW;

  logic [W-1:0]  regs [NREG];
  logic          c_flag;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W-1:0]  op_b_sel;
  logic          cin;
  logic          hz;
  logic          rd_we_q;
  logic          carry_we_q;
  logic [AW-1:0] h_rs_a;
  logic [AW-1:0] h_rs_b;
  logic          h_use_imm;
  logic          h_uses_carry;
  logic          refresh_a;
  logic          refresh_b;
  logic          refresh_c;

  always_comb begin
    op_a = regs[rs_a];
    if (wb_en && (wb_rd == rs_a)) op_a = wb_data;
    op_b = regs[rs_b];
    if (wb_en && (wb_rd == rs_b)) op_b = wb_data;
    op_b_sel = use_imm ? imm_in : op_b;
    cin      = wb_carry_en ? wb_carry : c_flag;
  end

  assign ex_rd_we    = ex_valid & rd_we_q;
  assign ex_carry_we = ex_valid & carry_we_q;

  assign hz = in_valid && ex_valid &&
              ((ex_rd_we && ((ex_rd == rs_a) || (!use_imm && (ex_rd == rs_b)))) ||
               (ex_carry_we && uses_carry_in));

  assign in_ready = !Reset && !stall && !hz;

  // A held entry keeps its source tags so late writebacks can still reach it.
  assign refresh_a = ex_valid && wb_en && (wb_rd == h_rs_a);
  assign refresh_b = ex_valid && wb_en && !h_use_imm && (wb_rd == h_rs_b);
  assign refresh_c = h_uses_carry && wb_carry_en;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      c_flag <= 1'b0;
    end else begin
      if (wb_en)       regs[wb_rd] <= wb_data;
      if (wb_carry_en) c_flag      <= wb_carry;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_valid     <= 1'b0;
      InputA       <= '0;
      InputB       <= '0;
      OP           <= '0;
      funct        <= '0;
      carry_in     <= 1'b0;
      ex_rd        <= '0;
      rd_we_q      <= 1'b0;
      carry_we_q   <= 1'b0;
      h_rs_a       <= '0;
      h_rs_b       <= '0;
      h_use_imm    <= 1'b0;
      h_uses_carry <= 1'b0;
    end else if (stall) begin
      if (refresh_a) InputA   <= wb_data;
      if (refresh_b) InputB   <= wb_data;
      if (refresh_c) carry_in <= wb_carry;
    end else if (hz) begin
      ex_valid <= 1'b0;
    end else begin
      ex_valid <= in_valid;
      if (in_valid) begin
        InputA       <= op_a;
        InputB       <= op_b_sel;
        OP           <= op_in;
        funct        <= funct_in;
        carry_in     <= cin;
        ex_rd        <= rd_in;
        rd_we_q      <= rd_we_in;
        carry_we_q   <= carry_we_in;
        h_rs_a       <= rs_a;
        h_rs_b       <= rs_b;
        h_use_imm    <= use_imm;
        h_uses_carry <= uses_carry_in;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed plan steps followed by random traffic,
// every cycle compared against a behavioural model of registers and EX entry.
module tb_operand_fetch_stage;
  logic       Clk;
  logic       Reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] rs_a;
  logic [2:0] rs_b;
  logic       use_imm;
  logic [7:0] imm_in;
  logic [3:0] op_in;
  logic [1:0] funct_in;
  logic [2:0] rd_in;
  logic       rd_we_in;
  logic       carry_we_in;
  logic       uses_carry_in;
  logic       stall;
  logic       ex_valid;
  logic [7:0] InputA;
  logic [7:0] InputB;
  logic [3:0] OP;
  logic [1:0] funct;
  logic       carry_in;
  logic [2:0] ex_rd;
  logic       ex_rd_we;
  logic       ex_carry_we;
  logic       wb_en;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       wb_carry_en;
  logic       wb_carry;

  operand_fetch_stage #(.W(8), .AW(3)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs_a(rs_a), .rs_b(rs_b), .use_imm(use_imm), .imm_in(imm_in),
    .op_in(op_in), .funct_in(funct_in), .rd_in(rd_in), .rd_we_in(rd_we_in),
    .carry_we_in(carry_we_in), .uses_carry_in(uses_carry_in), .stall(stall),
    .ex_valid(ex_valid), .InputA(InputA), .InputB(InputB), .OP(OP),
    .funct(funct), .carry_in(carry_in), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .ex_carry_we(ex_carry_we), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_carry_en(wb_carry_en), .wb_carry(wb_carry)
  );

  // clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model: architectural registers plus the one entry sitting in EX
  typedef struct {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [1:0] fn;
    logic       c;
    logic [2:0] rd;
    logic       rd_we;
    logic       cwe;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic       imm;
    logic       uc;
  } entry_t;

  entry_t     m_ex;
  logic [7:0] m_r [8];
  logic       m_c;
  logic       chk_pay;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] a);
    return (wb_en && wb_rd == a) ? wb_data : m_r[a];
  endfunction

  function automatic logic m_hazard();
    logic dep;
    dep = (m_ex.rd_we && (m_ex.rd == rs_a || (!use_imm && m_ex.rd == rs_b))) ||
          (m_ex.cwe && uses_carry_in);
    return in_valid && m_ex.v && dep;
  endfunction

  task automatic model_clear();
    m_ex.v = 0; m_ex.a = 0; m_ex.b = 0; m_ex.op = 0; m_ex.fn = 0; m_ex.c = 0;
    m_ex.rd = 0; m_ex.rd_we = 0; m_ex.cwe = 0; m_ex.src_a = 0; m_ex.src_b = 0;
    m_ex.imm = 0; m_ex.uc = 0;
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_c = 1'b0;
  endtask

  // advances the model by one clock edge using the inputs currently applied
  task automatic model_step();
    if (Reset) begin
      model_clear();
      chk_pay = 1'b1;
      return;
    end
    chk_pay = 1'b0;
    if (stall) begin
      if (m_ex.v && wb_en && wb_rd == m_ex.src_a) m_ex.a = wb_data;
      if (m_ex.v && wb_en && !m_ex.imm && wb_rd == m_ex.src_b) m_ex.b = wb_data;
      if (m_ex.uc && wb_carry_en) m_ex.c = wb_carry;
    end else if (m_hazard() || !in_valid) begin
      m_ex.v = 1'b0;
    end else begin
      m_ex.v     = 1'b1;
      m_ex.a     = m_read(rs_a);
      m_ex.b     = use_imm ? imm_in : m_read(rs_b);
      m_ex.op    = op_in;
      m_ex.fn    = funct_in;
      m_ex.c     = wb_carry_en ? wb_carry : m_c;
      m_ex.rd    = rd_in;
      m_ex.rd_we = rd_we_in;
      m_ex.cwe   = carry_we_in;
      m_ex.src_a = rs_a;
      m_ex.src_b = rs_b;
      m_ex.imm   = use_imm;
      m_ex.uc    = uses_carry_in;
    end
    if (wb_en) m_r[wb_rd] = wb_data;
    if (wb_carry_en) m_c = wb_carry;
  endtask

  // one clock: check in_ready mid-cycle, step model, check outputs after edge
  task automatic cycle();
    @(negedge Clk);
    chk("in_ready", in_ready, !Reset && !stall && !m_hazard());
    model_step();
    @(posedge Clk);
    #1;
    chk("ex_valid", ex_valid, m_ex.v);
    chk("ex_rd_we", ex_rd_we, m_ex.v & m_ex.rd_we);
    chk("ex_carry_we", ex_carry_we, m_ex.v & m_ex.cwe);
    if (m_ex.v || chk_pay) begin
      chk("InputA", InputA, m_ex.a);
      chk("InputB", InputB, m_ex.b);
      chk("OP", OP, m_ex.op);
      chk("funct", funct, m_ex.fn);
      chk("carry_in", carry_in, m_ex.c);
      chk("ex_rd", ex_rd, m_ex.rd);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    Reset = 0; in_valid = 0; rs_a = 0; rs_b = 0; use_imm = 0; imm_in = 0;
    op_in = 0; funct_in = 0; rd_in = 0; rd_we_in = 0; carry_we_in = 0;
    uses_carry_in = 0; stall = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    wb_carry_en = 0; wb_carry = 0;
  endtask

  task automatic drive_instr(input logic [2:0] a, input logic [2:0] b, input logic imm,
                             input logic [7:0] immv, input logic [2:0] rd, input logic we);
    in_valid = 1; rs_a = a; rs_b = b; use_imm = imm; imm_in = immv;
    rd_in = rd; rd_we_in = we;
  endtask

  task automatic drive_random();
    Reset         = ($urandom_range(0, 63) == 0);
    stall         = ($urandom_range(0, 3) == 0);
    in_valid      = $urandom_range(0, 1);
    rs_a          = 3'($urandom_range(0, 7));
    rs_b          = 3'($urandom_range(0, 7));
    use_imm       = ($urandom_range(0, 3) == 0);
    imm_in        = 8'($urandom);
    op_in         = 4'($urandom);
    funct_in      = 2'($urandom);
    rd_in         = 3'($urandom_range(0, 7));
    rd_we_in      = $urandom_range(0, 1);
    carry_we_in   = ($urandom_range(0, 2) == 0);
    uses_carry_in = ($urandom_range(0, 2) == 0);
    wb_en         = $urandom_range(0, 1);
    wb_rd         = 3'($urandom_range(0, 7));
    wb_data       = 8'($urandom);
    wb_carry_en   = ($urandom_range(0, 2) == 0);
    wb_carry      = $urandom_range(0, 1);
  endtask

  initial begin
    model_clear();
    chk_pay = 1'b0;
    drive_idle();

    // reset with a writeback attempted underneath it
    Reset = 1; wb_en = 1; wb_rd = 3; wb_data = 8'hFF;
    cycle();
    cycle();
    chk("reset_ex_valid", ex_valid, 0);
    chk("reset_InputA", InputA, 0);
    drive_idle();
    drive_instr(3, 3, 0, 0, 0, 0);
    cycle();
    chk("r3_after_reset", InputA, 8'h00);

    // same-cycle bypass on both ports, then plain register read
    drive_instr(2, 2, 0, 0, 0, 0);
    wb_en = 1; wb_rd = 2; wb_data = 8'h5A;
    cycle();
    chk("bypass_a", InputA, 8'h5A);
    chk("bypass_b", InputB, 8'h5A);
    drive_idle();
    drive_instr(2, 0, 0, 0, 0, 0);
    cycle();
    chk("r2_read", InputA, 8'h5A);

    // immediate operand with carry bypass
    drive_idle();
    wb_en = 1; wb_rd = 1; wb_data = 8'h10;
    cycle();
    drive_idle();
    drive_instr(1, 0, 1, 8'h04, 0, 0);
    uses_carry_in = 1; wb_carry_en = 1; wb_carry = 1;
    cycle();
    chk("imm_a", InputA, 8'h10);
    chk("imm_b", InputB, 8'h04);
    chk("imm_cin", carry_in, 1);

    // interlock: producer of R5, then a consumer of R5 on port B
    drive_idle();
    drive_instr(0, 0, 0, 0, 5, 1);
    cycle();
    drive_idle();
    drive_instr(0, 5, 0, 0, 0, 0);
    #1;
    chk("hz_in_ready", in_ready, 0);
    cycle();
    chk("hz_bubble", ex_valid, 0);
    wb_en = 1; wb_rd = 5; wb_data = 8'h33;
    cycle();
    chk("hz_issue_valid", ex_valid, 1);
    chk("hz_issue_b", InputB, 8'h33);
    drive_idle();
    drive_instr(0, 0, 0, 0, 5, 1);
    cycle();
    drive_idle();
    drive_instr(0, 5, 1, 8'h77, 0, 0);
    cycle();
    chk("imm_no_bubble", ex_valid, 1);
    chk("imm_no_bubble_b", InputB, 8'h77);

    // stall with a writeback hitting the held rs_a in the second cycle
    drive_idle();
    drive_instr(4, 0, 0, 0, 6, 0);
    op_in = 4'h9; funct_in = 2'h2;
    cycle();
    drive_idle();
    drive_instr(1, 2, 0, 0, 3, 1);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      wb_en = (k == 1); wb_rd = 4; wb_data = 8'hA1;
      cycle();
      chk("stall_in_ready", in_ready, 0);
    end
    chk("stall_refresh_a", InputA, 8'hA1);
    chk("stall_op_held", OP, 4'h9);
    chk("stall_rd_held", ex_rd, 3'd6);

    // reset while stalled discards the held entry
    wb_en = 0;
    Reset = 1;
    cycle();
    chk("rst_stall_valid", ex_valid, 0);
    chk("rst_stall_a", InputA, 0);
    chk("rst_stall_op", OP, 0);
    drive_idle();
    cycle();

    // random traffic against the model
    for (int n = 0; n < 800; n++) begin
      drive_random();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
